// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC sequencer.
// Defining CORDIC_GAIN_COMP_EN adds the SCALE state used for gain compensation.
package cordic_pkg;

    localparam int unsigned CordicWidth    = 15;
    localparam int unsigned CordicGuard    = 2;
    localparam int unsigned CordicIntWidth = CordicWidth + CordicGuard;
    localparam int unsigned IterW          = 4;
    localparam int unsigned AtanW          = 14;
    localparam int unsigned GainFrac       = 14;
    localparam logic [15:0] GainK          = 16'h26DD;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRot   = 2'd1,
`ifdef CORDIC_GAIN_COMP_EN
        StScale = 2'd3,
`endif
        StDone  = 2'd2
    } state_e;

    // atan(2^-i) in radians at 2^-14; beyond the table the angle step is zero
    function automatic logic [AtanW-1:0] atan_rom(input logic [IterW-1:0] idx);
        logic [AtanW-1:0] v;
        case (idx)
            4'd0:    v = 14'h3243;
            4'd1:    v = 14'h1DAC;
            4'd2:    v = 14'h0FAD;
            4'd3:    v = 14'h07F5;
            4'd4:    v = 14'h03FE;
            4'd5:    v = 14'h01FF;
            4'd6:    v = 14'h00FF;
            4'd7:    v = 14'h007F;
            4'd8:    v = 14'h003F;
            4'd9:    v = 14'h001F;
            4'd10:   v = 14'h000F;
            4'd11:   v = 14'h0007;
            4'd12:   v = 14'h0003;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_rot_step.sv
// Combinational single CORDIC micro-rotation; shared by iterative and unrolled datapaths.
module cordic_rot_step
    import cordic_pkg::*;
#(
    parameter int unsigned IW = CordicIntWidth
) (
    input  logic signed [IW-1:0]    x_i,
    input  logic signed [IW-1:0]    y_i,
    input  logic signed [IW-1:0]    z_i,
    input  logic        [IterW-1:0] iter_i,
    input  logic                    mode_i,
    output logic signed [IW-1:0]    x_o,
    output logic signed [IW-1:0]    y_o,
    output logic signed [IW-1:0]    z_o
);

    logic signed [IW-1:0] x_sh;
    logic signed [IW-1:0] y_sh;
    logic signed [IW-1:0] atan_v;
    logic                 neg_d;

    always_comb begin
        x_sh   = x_i >>> iter_i;
        y_sh   = y_i >>> iter_i;
        atan_v = IW'(atan_rom(iter_i));
        // Vectoring drives y toward zero: d = -1 only for strictly positive y
        neg_d  = mode_i ? (!y_i[IW-1] && (y_i != '0)) : z_i[IW-1];
        if (neg_d) begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_v;
        end else begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_v;
        end
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC sequencer: one shared micro-rotation stage, ORDER+1 iterations per job.
// CORDIC_GAIN_COMP_EN enables a SCALE state that removes the CORDIC gain from x/y.
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = CordicWidth,
    parameter int unsigned ORDER = 12,
    parameter int unsigned GUARD = CordicGuard
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic signed [WIDTH-1:0] in_z,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_x,
    output logic signed [WIDTH-1:0] out_y,
    output logic signed [WIDTH-1:0] out_z,
    output logic                    busy
);

    localparam int unsigned IW = WIDTH + GUARD;

    state_e               state_q, state_d;
    logic [IterW-1:0]     iter_q, iter_d;
    logic                 mode_q, mode_d;
    logic signed [IW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [IW-1:0] rot_x, rot_y, rot_z;
    logic [WIDTH-1:0]     out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;

    function automatic logic [WIDTH-1:0] sat(input logic [IW-1:0] v);
        logic [IW-WIDTH:0] top;
        top = v[IW-1:WIDTH-1];
        if ((&top) || !(|top)) begin
            return v[WIDTH-1:0];
        end
        return v[IW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

`ifdef CORDIC_GAIN_COMP_EN
    localparam int unsigned PW = IW + GainFrac;

    // v * K / 2^14 via shift-add; dropping the low bits floors toward -inf
    function automatic logic [IW-1:0] gain_scale(input logic [IW-1:0] v);
        logic signed [PW-1:0] ve;
        logic signed [PW-1:0] acc;
        ve  = $signed({{GainFrac{v[IW-1]}}, v});
        acc = '0;
        for (int b = 0; b < 16; b++) begin
            if (GainK[b]) begin
                acc = acc + (ve <<< b);
            end
        end
        return acc[PW-1:GainFrac];
    endfunction
`endif

    cordic_rot_step #(
        .IW(IW)
    ) u_rot_step (
        .x_i   (x_q),
        .y_i   (y_q),
        .z_i   (z_q),
        .iter_i(iter_q),
        .mode_i(mode_q),
        .x_o   (rot_x),
        .y_o   (rot_y),
        .z_o   (rot_z)
    );

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        out_x_d = out_x_q;
        out_y_d = out_y_q;
        out_z_d = out_z_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d     = {{GUARD{in_x[WIDTH-1]}}, in_x};
                    y_d     = {{GUARD{in_y[WIDTH-1]}}, in_y};
                    z_d     = {{GUARD{in_z[WIDTH-1]}}, in_z};
                    mode_d  = in_mode;
                    iter_d  = '0;
                    state_d = StRot;
                end
            end
            StRot: begin
                x_d    = rot_x;
                y_d    = rot_y;
                z_d    = rot_z;
                iter_d = iter_q + 1'b1;
                if (iter_q == IterW'(ORDER)) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = StScale;
`else
                    out_x_d = sat(rot_x);
                    out_y_d = sat(rot_y);
                    out_z_d = sat(rot_z);
                    state_d = StDone;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            StScale: begin
                x_d     = gain_scale(x_q);
                y_d     = gain_scale(y_q);
                out_x_d = sat(gain_scale(x_q));
                out_y_d = sat(gain_scale(y_q));
                out_z_d = sat(z_q);
                state_d = StDone;
            end
`endif
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            iter_q  <= '0;
            mode_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            out_x_q <= '0;
            out_y_q <= '0;
            out_z_q <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            out_x_q <= out_x_d;
            out_y_q <= out_y_d;
            out_z_q <= out_z_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_z     = out_z_q;

endmodule

// File: doc/cordic_iter_ctrl.md
Name: cordic_iter_ctrl

Overview:
- Iterative CORDIC sequencer that time-shares one micro-rotation stage over ORDER+1 iterations, replacing the unrolled per-order element chain when area matters more than throughput.
- Accepts one (x, y, z, mode) job over a valid/ready handshake and runs the FSM and iteration counter.
- Selects arctan constants from a ROM and returns a saturated result over a second valid/ready handshake.
- Sits between the angle/vector producer and downstream trig consumers.

Parameters:
- WIDTH, 15: I/O word width, signed two's complement, Q1.14 (1.0 = 0x4000; angles in radians at 2^-14).
- ORDER, 12: last iteration index; ORDER+1 micro-rotations per job. Legal range 1..12, bounded by the ROM depth.
- GUARD, 2: extra MSBs on internal x/y/z registers to absorb CORDIC gain growth.

Ports:
- CLK, input, 1: clock; all state updates on rising edge.
- RESET, input, 1: synchronous, active-high reset.
- in_valid, input, 1: job request.
- in_ready, output, 1: block can accept a job (high only in IDLE).
- in_mode, input, 1: 0 = rotation (d = sign z), 1 = vectoring (d = -sign y).
- in_x, input, WIDTH: initial x.
- in_y, input, WIDTH: initial y.
- in_z, input, WIDTH: initial angle; |z| < 1.0 rad.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts result.
- out_x, output, WIDTH: final x, saturated.
- out_y, output, WIDTH: final y, saturated.
- out_z, output, WIDTH: final z, saturated.
- busy, output, 1: high whenever state != IDLE.

Behaviour:
- Reset: state = IDLE, iteration counter = 0, internal x/y/z = 0, out_x/out_y/out_z = 0, out_valid = 0, busy = 0, in_ready = 1 on the first cycle after reset.
- States: IDLE, ROT, SCALE (present only with the optional feature), DONE.
- IDLE: on in_valid & in_ready, sign-extend inputs into x/y/z (WIDTH+GUARD bits), latch mode, set iter = 0, go to ROT. Inputs are ignored when in_valid = 0.
- ROT, one micro-rotation per edge:
  - x' = x - d*(y>>>iter); y' = y + d*(x>>>iter); z' = z - d*ATAN[iter]; arithmetic shifts.
  - d = +1 when the decision operand is >= 0 (z in rotation mode, -y in vectoring mode), else -1; zero counts as positive.
  - iter increments each edge. The edge performing iter == ORDER goes to DONE (or SCALE).
- SCALE: multiply x and y by K = 0x26DD (Q1.14) using shift-add, truncate toward -inf. z is unchanged. One edge, then DONE.
- DONE: out_valid = 1 and outputs hold stable. On out_valid & out_ready, go to IDLE and clear out_valid; the next job can be accepted on the following cycle. There is no back-to-back accept in the same edge.
- Latency: accept edge to out_valid high = ORDER+1 edges (13 by default), +1 with SCALE. Throughput is one job per ORDER+3 cycles when out_ready is held high.
- Saturation: outputs clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1] when the internal value exceeds WIDTH bits.
- RESET has priority over every handshake. A reset mid-job discards the job and produces no out_valid.
- out_ready while not in DONE has no effect. in_valid while busy is not accepted and the producer must hold it.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined: SCALE state compensates the gain; magnitudes come out unscaled (≈1/1.6468 of the raw value).
- Undefined: SCALE state and multiplier are absent; x/y carry the CORDIC gain (≈1.6468); latency is ORDER+1.

Decomposition:
- Package cordic_pkg holds:
  - state enum;
  - ATAN ROM constants 0x3243, 0x1DAC, 0x0FAD, 0x07F5, 0x03FE, 0x01FF, 0x00FF, 0x007F, 0x003F, 0x001F, 0x000F, 0x0007, 0x0003;
  - gain constant K = 0x26DD;
  - localparam for the internal width.
- Sub-module cordic_rot_step: combinational single micro-rotation (x, y, z, iter, mode → x', y', z'). It is reused by any future unrolled variant.

Test Plan:
1. Rotation, gain comp off: x=0x2000, y=0, z=0x3244 → out_x ≈ out_y ≈ 0x2543 (±4 LSB), out_z ≈ 0 (±4); out_valid exactly 13 cycles after accept.
2. Rotation, gain comp on: same stimulus → out_x ≈ out_y ≈ 0x16A1 (±4), out_valid 14 cycles after accept.
3. Vectoring, gain comp off: x=0x2000, y=0x2000 → out_z ≈ 0x3244 (±4), out_y ≈ 0; out_x saturates to 0x3FFF.
4. Backpressure: hold out_ready=0 for 20 cycles after DONE → outputs stable, in_ready=0, a second in_valid is not accepted; the second job is accepted one cycle after out_ready rises.
5. RESET asserted at iteration 5 → next cycle state IDLE, outputs 0, out_valid never pulses for the aborted job; a fresh job then completes correctly.
6. Negative angle rotation: x=0x4000 is out of range (+1.0 is not representable in Q1.14 at WIDTH=15), so use x=0x3FFF, y=0, z=0xCDBC (-π/4) with gain comp on → out_x ≈ 0x2D41, out_y ≈ 0xD2BF (±4).
